// File: rtl/timer_irq_pkg.sv
// timer_irq_pkg: shared definitions for the timer interrupt controller.
//   - FSM state encoding (HOLDOFF present only with TIMER_IRQ_HOLDOFF_EN)
//   - default vector numbers for the four timer sources
//   - TIFRx/TIMSKx bit positions
//   - source indices into the pending/select vectors (index 0 = highest priority)
// Optional feature macro: TIMER_IRQ_HOLDOFF_EN
package timer_irq_pkg;

`ifdef TIMER_IRQ_HOLDOFF_EN
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2,
    HOLDOFF = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_e;
`endif

  localparam int unsigned DEF_VEC_T1_COMPA = 8;
  localparam int unsigned DEF_VEC_T1_OVF   = 10;
  localparam int unsigned DEF_VEC_T0_COMP  = 11;
  localparam int unsigned DEF_VEC_T0_OVF   = 12;

  localparam int unsigned BIT_OCF0  = 1;
  localparam int unsigned BIT_TOV0  = 0;
  localparam int unsigned BIT_OCF1A = 4;
  localparam int unsigned BIT_TOV1  = 0;

  localparam int unsigned SRC_N        = 4;
  localparam int unsigned SRC_T1_COMPA = 0;
  localparam int unsigned SRC_T1_OVF   = 1;
  localparam int unsigned SRC_T0_COMP  = 2;
  localparam int unsigned SRC_T0_OVF   = 3;

endpackage

// File: rtl/timer_irq_prio_enc.sv
// timer_irq_prio_enc: fixed-priority select over the four pending sources.
// Ports:
//   pend   in  [SRC_N-1:0]  pending bits, index 0 has highest priority
//   valid  out              any source pending
//   vector out [VEC_W-1:0]  vector number of the winning source (0 if none)
//   sel    out [SRC_N-1:0]  one-hot select of the winning source
module timer_irq_prio_enc
  import timer_irq_pkg::*;
#(
  parameter int unsigned VEC_W = 5,
  parameter int unsigned VEC0  = DEF_VEC_T1_COMPA,
  parameter int unsigned VEC1  = DEF_VEC_T1_OVF,
  parameter int unsigned VEC2  = DEF_VEC_T0_COMP,
  parameter int unsigned VEC3  = DEF_VEC_T0_OVF
) (
  input  logic [SRC_N-1:0] pend,
  output logic             valid,
  output logic [VEC_W-1:0] vector,
  output logic [SRC_N-1:0] sel
);

  always_comb begin
    valid  = |pend;
    vector = '0;
    sel    = '0;
    if (pend[0]) begin
      vector = VEC_W'(VEC0);
      sel    = 4'b0001;
    end else if (pend[1]) begin
      vector = VEC_W'(VEC1);
      sel    = 4'b0010;
    end else if (pend[2]) begin
      vector = VEC_W'(VEC2);
      sel    = 4'b0100;
    end else if (pend[3]) begin
      vector = VEC_W'(VEC3);
      sel    = 4'b1000;
    end
  end

endmodule

// File: rtl/timer_irq_controller.sv
// timer_irq_controller: arbitrates Timer0/Timer1 interrupt flags into a single
// CPU request with a latched vector, and strobes the hardware flag clear for
// the accepted source.
// Ports:
//   sysClock      in        system clock, rising edge
//   system_reset  in        asynchronous active-low reset
//   tifr0/timsk0  in  [7:0] Timer0 flags/mask (bit1 OCF0, bit0 TOV0)
//   tifr1/timsk1  in  [7:0] Timer1 flags/mask (bit4 OCF1A, bit0 TOV1)
//   global_ie     in        SREG I-bit
//   irq_ack       in        CPU accepts the presented vector
//   reti          in        CPU executed RETI
//   irq_req       out       interrupt request
//   irq_vector    out [VEC_W-1:0] vector of the presented request
//   flag_clr0/1   out [7:0] one-cycle flag-clear strobes
// Optional feature macro: TIMER_IRQ_HOLDOFF_EN (one idle cycle after RETI)
module timer_irq_controller
  import timer_irq_pkg::*;
#(
  parameter int unsigned VEC_W        = 5,
  parameter int unsigned VEC_T1_COMPA = DEF_VEC_T1_COMPA,
  parameter int unsigned VEC_T1_OVF   = DEF_VEC_T1_OVF,
  parameter int unsigned VEC_T0_COMP  = DEF_VEC_T0_COMP,
  parameter int unsigned VEC_T0_OVF   = DEF_VEC_T0_OVF
) (
  input  logic             sysClock,
  input  logic             system_reset,
  input  logic [7:0]       tifr0,
  input  logic [7:0]       timsk0,
  input  logic [7:0]       tifr1,
  input  logic [7:0]       timsk1,
  input  logic             global_ie,
  input  logic             irq_ack,
  input  logic             reti,
  output logic             irq_req,
  output logic [VEC_W-1:0] irq_vector,
  output logic [7:0]       flag_clr0,
  output logic [7:0]       flag_clr1
);

  state_e             state_q, state_d;
  logic               req_q, req_d;
  logic [VEC_W-1:0]   vector_q, vector_d;
  logic [SRC_N-1:0]   sel_q, sel_d;
  logic [7:0]         clr0_q, clr0_d;
  logic [7:0]         clr1_q, clr1_d;

  logic [SRC_N-1:0]   pend;
  logic               enc_valid;
  logic [VEC_W-1:0]   enc_vector;
  logic [SRC_N-1:0]   enc_sel;
  logic               sel_still_pending;

  always_comb begin
    pend               = '0;
    pend[SRC_T1_COMPA] = tifr1[BIT_OCF1A] & timsk1[BIT_OCF1A];
    pend[SRC_T1_OVF]   = tifr1[BIT_TOV1]  & timsk1[BIT_TOV1];
    pend[SRC_T0_COMP]  = tifr0[BIT_OCF0]  & timsk0[BIT_OCF0];
    pend[SRC_T0_OVF]   = tifr0[BIT_TOV0]  & timsk0[BIT_TOV0];
  end

  timer_irq_prio_enc #(
    .VEC_W (VEC_W),
    .VEC0  (VEC_T1_COMPA),
    .VEC1  (VEC_T1_OVF),
    .VEC2  (VEC_T0_COMP),
    .VEC3  (VEC_T0_OVF)
  ) u_prio (
    .pend   (pend),
    .valid  (enc_valid),
    .vector (enc_vector),
    .sel    (enc_sel)
  );

  // The latched source, not the current winner, decides whether to withdraw.
  assign sel_still_pending = |(sel_q & pend);

  always_comb begin
    state_d  = state_q;
    req_d    = 1'b0;
    vector_d = vector_q;
    sel_d    = sel_q;
    clr0_d   = '0;
    clr1_d   = '0;
    case (state_q)
      IDLE: begin
        if (global_ie && enc_valid) begin
          state_d  = REQ;
          req_d    = 1'b1;
          vector_d = enc_vector;
          sel_d    = enc_sel;
        end
      end
      REQ: begin
        // Ack takes precedence over a simultaneous withdraw condition.
        if (irq_ack) begin
          state_d           = SERVICE;
          clr1_d[BIT_OCF1A] = sel_q[SRC_T1_COMPA];
          clr1_d[BIT_TOV1]  = sel_q[SRC_T1_OVF];
          clr0_d[BIT_OCF0]  = sel_q[SRC_T0_COMP];
          clr0_d[BIT_TOV0]  = sel_q[SRC_T0_OVF];
        end else if (!global_ie || !sel_still_pending) begin
          state_d = IDLE;
        end else begin
          req_d = 1'b1;
        end
      end
      SERVICE: begin
        if (reti) begin
`ifdef TIMER_IRQ_HOLDOFF_EN
          state_d = HOLDOFF;
`else
          state_d = IDLE;
`endif
        end
      end
`ifdef TIMER_IRQ_HOLDOFF_EN
      HOLDOFF: state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sysClock or negedge system_reset) begin
    if (!system_reset) begin
      state_q  <= IDLE;
      req_q    <= 1'b0;
      vector_q <= '0;
      sel_q    <= '0;
      clr0_q   <= '0;
      clr1_q   <= '0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      vector_q <= vector_d;
      sel_q    <= sel_d;
      clr0_q   <= clr0_d;
      clr1_q   <= clr1_d;
    end
  end

  assign irq_req    = req_q;
  assign irq_vector = vector_q;
  assign flag_clr0  = clr0_q;
  assign flag_clr1  = clr1_q;

endmodule
